// File: rtl/sonic_display_pkg.sv
// Shared constants and types for the sonic display datapath.
package sonic_display_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [3:0] DIGIT_NINE = 4'h9;

  // Display select codes beyond the ten decimal digits
  localparam int unsigned DASH_SEL  = 16;
  localparam int unsigned BLANK_SEL = 17;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adjust
  import sonic_display_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  // Pure combinational add-3 correction
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Iterative double-dabble binary to packed BCD converter with leading-zero blank mask
// and overflow saturation. One conversion in flight, start/busy/valid handshake.
module bin_to_bcd_converter
  import sonic_display_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned DIGITS   = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [IN_WIDTH-1:0]       bin_in,
  output logic                      busy_out,
  output logic                      valid_out,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]         blank_mask_out,
  output logic                      overflow_out
);

  localparam int unsigned BcdW = BCD_W * DIGITS;
  localparam int unsigned SrW  = BcdW + IN_WIDTH;
  localparam int unsigned CntW = $clog2(IN_WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(IN_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [SrW-1:0]    sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              ovf_out_q, ovf_out_d;

  logic [SrW-1:0]    adj_sr;
  logic [SrW-1:0]    shifted;
  logic              shift_out;
  logic              ovf_final;
  logic [BcdW-1:0]   final_bcd;
  logic [DIGITS-1:0] final_mask;

  // Per-digit add-3 correction on the BCD portion of the shift register
  for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
    bcd_digit_adjust u_adj (
      .digit_i(sr_q[IN_WIDTH + BCD_W*g +: BCD_W]),
      .digit_o(adj_sr[IN_WIDTH + BCD_W*g +: BCD_W])
    );
  end
  assign adj_sr[IN_WIDTH-1:0] = sr_q[IN_WIDTH-1:0];

  assign shifted   = {adj_sr[SrW-2:0], 1'b0};
  assign shift_out = adj_sr[SrW-1];
  assign ovf_final = ovf_q | shift_out;

  // Final digits and leading-zero mask as they will look after the last shift
  always_comb begin
    logic all_zero;
    final_bcd  = ovf_final ? {DIGITS{DIGIT_NINE}} : shifted[SrW-1 -: BcdW];
    final_mask = '0;
    all_zero   = !ovf_final;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero      = all_zero && (shifted[IN_WIDTH + BCD_W*i +: BCD_W] == 4'd0);
      final_mask[i] = all_zero;
    end
  end

  // Next-state logic for the IDLE/SHIFT controller and output registers
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    mask_d    = mask_q;
    ovf_out_d = ovf_out_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          sr_d    = {{BcdW{1'b0}}, bin_in};
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = shifted;
        cnt_d = cnt_q + CntW'(1);
        ovf_d = ovf_final;
        if (cnt_q == LastCnt) begin
          bcd_d     = final_bcd;
          mask_d    = final_mask;
          ovf_out_d = ovf_final;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      mask_q    <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      mask_q    <= mask_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign busy_out       = busy_q;
  assign valid_out      = valid_q;
  assign bcd_out        = bcd_q;
  assign blank_mask_out = mask_q;
  assign overflow_out   = ovf_out_q;

endmodule
